// File: rtl/fighter_anim_seq.sv
// fighter_anim_seq: per-fighter animation/state sequencer.
// Turns key levels and an opponent-hit level into a registered state
// machine that steps sprite frames on frame_clk rising edges and emits
// one-Clk move pulses (1 px per video frame).
// Optional build macro: FIGHTER_KNOCKBACK_EN adds a 2 px leftward
// knockback (move_l pulses) on the first two ticks of HURT.
module fighter_anim_seq #(
  parameter int STAND_FRAMES    = 8,
  parameter int FWD_FRAMES      = 5,
  parameter int BWD_FRAMES      = 5,
  parameter int ATTACK_FRAMES   = 9,
  parameter int HURT_FRAMES     = 4,
  parameter int DEFEND_FRAMES   = 1,
  parameter int TICKS_PER_FRAME = 4,
  parameter int HIT_FIRST       = 4,
  parameter int HIT_LAST        = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       hit_in,
  output logic [7:0] character_state,
  output logic [7:0] frame_num,
  output logic       move_l,
  output logic       move_r,
  output logic       attack_active,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_ATTACK = 3'd1,
    ST_MOVEL  = 3'd2,
    ST_MOVER  = 3'd3,
    ST_HURT   = 3'd4,
    ST_DEFEND = 3'd5
  } state_t;

  localparam logic [7:0] LP_TPF_M1    = 8'(TICKS_PER_FRAME - 1);
  localparam logic [7:0] LP_HIT_FIRST = 8'(HIT_FIRST);
  localparam logic [7:0] LP_HIT_LAST  = 8'(HIT_LAST);

  // Index of the last sprite frame of a state.
  function automatic logic [7:0] last_frame(input state_t s);
    logic [7:0] v;
    case (s)
      ST_STAND:  v = 8'(STAND_FRAMES - 1);
      ST_ATTACK: v = 8'(ATTACK_FRAMES - 1);
      ST_MOVEL:  v = 8'(BWD_FRAMES - 1);
      ST_MOVER:  v = 8'(FWD_FRAMES - 1);
      ST_HURT:   v = 8'(HURT_FRAMES - 1);
      ST_DEFEND: v = 8'(DEFEND_FRAMES - 1);
      default:   v = 8'(STAND_FRAMES - 1);
    endcase
    return v;
  endfunction

  // Looping states may be interrupted by an attack request.
  function automatic logic is_loop(input state_t s);
    logic v;
    case (s)
      ST_STAND, ST_MOVEL, ST_MOVER, ST_DEFEND: v = 1'b1;
      default:                                 v = 1'b0;
    endcase
    return v;
  endfunction

  // Priority-ordered target state evaluated from base state s.
  function automatic state_t pick_target(input state_t s, input logic l,
                                         input logic r, input logic a,
                                         input logic d, input logic h);
    state_t t;
    if (h && (s != ST_HURT) && (s != ST_DEFEND)) begin
      t = ST_HURT;
    end else if (is_loop(s) && a) begin
      t = ST_ATTACK;
    end else if (d) begin
      t = ST_DEFEND;
    end else if (r && !l) begin
      t = ST_MOVER;
    end else if (l && !r) begin
      t = ST_MOVEL;
    end else begin
      t = ST_STAND;
    end
    return t;
  endfunction

  state_t     r_state;
  logic [7:0] r_frame;
  logic [7:0] r_sub;
  logic       r_fc_d;
  logic       r_move_l;
  logic       r_move_r;
  logic       r_attack_active;
  logic       r_busy;

  state_t     w_target;
  state_t     w_next_state;
  logic [7:0] w_next_frame;
  logic [7:0] w_next_sub;
  logic       w_tick;
  logic       w_frame_end;
  logic       w_last;
  logic       w_restart;
  logic       w_change;
  logic       w_kb;

  assign w_tick = frame_clk & ~r_fc_d;

  // Target selection and next frame/sub-tick counters for this tick.
  always_comb begin
    w_target     = r_state;
    w_restart    = 1'b0;
    w_next_state = r_state;
    w_next_frame = r_frame;
    w_next_sub   = r_sub;
    w_frame_end  = (r_sub == LP_TPF_M1);
    w_last       = (r_frame >= last_frame(r_state));
    if ((r_state == ST_ATTACK) || (r_state == ST_HURT)) begin
      // One-shots ignore keys; only a hit can cut an attack short.
      if ((r_state == ST_ATTACK) && hit_in) begin
        w_target = ST_HURT;
      end else if (w_frame_end && w_last) begin
        w_target  = pick_target(ST_STAND, key_left, key_right, key_attack,
                                key_defend, hit_in);
        w_restart = 1'b1;
      end else begin
        w_target = r_state;
      end
    end else begin
      w_target = pick_target(r_state, key_left, key_right, key_attack,
                             key_defend, hit_in);
    end
    w_change = w_tick && ((w_target != r_state) || w_restart);
    if (!w_tick) begin
      w_next_state = r_state;
    end else if (w_change) begin
      w_next_state = w_target;
      w_next_frame = 8'd0;
      w_next_sub   = 8'd0;
    end else if (w_frame_end) begin
      w_next_sub   = 8'd0;
      w_next_frame = w_last ? 8'd0 : (r_frame + 8'd1);
    end else begin
      w_next_sub = r_sub + 8'd1;
    end
  end

`ifdef FIGHTER_KNOCKBACK_EN
  // Knockback on the entry tick of HURT and the tick right after it.
  always_comb begin
    if (w_tick && (w_next_state == ST_HURT)) begin
      w_kb = (r_state != ST_HURT) || w_restart ||
             ((r_frame == 8'd0) && (r_sub == 8'd0));
    end else begin
      w_kb = 1'b0;
    end
  end
`else
  assign w_kb = 1'b0;
`endif

  // State, counters and all registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc_d          <= 1'b0;
      r_state         <= ST_STAND;
      r_frame         <= 8'd0;
      r_sub           <= 8'd0;
      r_move_l        <= 1'b0;
      r_move_r        <= 1'b0;
      r_attack_active <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_fc_d          <= frame_clk;
      r_state         <= w_next_state;
      r_frame         <= w_next_frame;
      r_sub           <= w_next_sub;
      r_move_r        <= w_tick && (w_next_state == ST_MOVER);
      r_move_l        <= (w_tick && (w_next_state == ST_MOVEL)) || w_kb;
      r_attack_active <= (w_next_state == ST_ATTACK) &&
                         (w_next_frame >= LP_HIT_FIRST) &&
                         (w_next_frame <= LP_HIT_LAST);
      r_busy          <= (w_next_state == ST_ATTACK) ||
                         (w_next_state == ST_HURT);
    end
  end

  assign character_state = {5'd0, r_state};
  assign frame_num       = r_frame;
  assign move_l          = r_move_l;
  assign move_r          = r_move_r;
  assign attack_active   = r_attack_active;
  assign busy            = r_busy;

endmodule

// File: tb/tb_fighter_anim_seq.sv
// Directed, table-driven bench for fighter_anim_seq (default parameters).
module tb_fighter_anim_seq;

`ifdef FIGHTER_KNOCKBACK_EN
  localparam logic KB = 1'b1;
`else
  localparam logic KB = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_attack = 1'b0;
  logic       key_defend = 1'b0;
  logic       hit_in = 1'b0;
  logic [7:0] character_state;
  logic [7:0] frame_num;
  logic       move_l;
  logic       move_r;
  logic       attack_active;
  logic       busy;

  fighter_anim_seq dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_attack(key_attack),
    .key_defend(key_defend), .hit_in(hit_in),
    .character_state(character_state), .frame_num(frame_num),
    .move_l(move_l), .move_r(move_r),
    .attack_active(attack_active), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic l, r, a, d, h;
    int   st, fr;
    logic ml, mr, aa, bz;
  } vec_t;

  vec_t tbl[24];
  int   n_pass = 0;
  int   n_total = 0;
  int   s_st, s_fr;
  logic s_ml, s_mr, s_aa, s_bz;

  function automatic vec_t mk(input logic l, r, a, d, h, input int st, fr,
                              input logic ml, mr, aa, bz);
    vec_t v;
    v.l = l; v.r = r; v.a = a; v.d = d; v.h = h;
    v.st = st; v.fr = fr; v.ml = ml; v.mr = mr; v.aa = aa; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_attack = 1'b0;
    key_defend = 1'b0; hit_in = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One frame_clk pulse; outputs snapshotted one Clk after the rise,
  // then move pulses must already be gone on the following Clk.
  task automatic do_tick(input logic l, r, a, d, h);
    @(negedge Clk);
    key_left = l; key_right = r; key_attack = a; key_defend = d; hit_in = h;
    frame_clk = 1'b1;
    @(negedge Clk);
    s_st = int'(character_state); s_fr = int'(frame_num);
    s_ml = move_l; s_mr = move_r; s_aa = attack_active; s_bz = busy;
    frame_clk = 1'b0;
    @(negedge Clk);
    chk("pulse_clear", int'(move_l | move_r), 0);
  endtask

  task automatic chk_snap(input string tag, input int st, fr,
                          input logic ml, mr, aa, bz);
    chk({tag, ".state"}, s_st, st);
    chk({tag, ".frame"}, s_fr, fr);
    chk({tag, ".move_l"}, int'(s_ml), int'(ml));
    chk({tag, ".move_r"}, int'(s_mr), int'(mr));
    chk({tag, ".attack_active"}, int'(s_aa), int'(aa));
    chk({tag, ".busy"}, int'(s_bz), int'(bz));
  endtask

  initial begin
    int aa_cnt;
    int mr_cnt;
    //              l     r     a     d     h    st fr ml    mr    aa    bz
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, KB,   1'b0, 1'b0, 1'b1);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, KB,   1'b0, 1'b0, 1'b1);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state.
    do_reset();
    @(negedge Clk);
    chk("reset.state", int'(character_state), 0);
    chk("reset.frame", int'(frame_num), 0);
    chk("reset.move_l", int'(move_l), 0);
    chk("reset.move_r", int'(move_r), 0);
    chk("reset.attack_active", int'(attack_active), 0);
    chk("reset.busy", int'(busy), 0);

    // Idle stand loop: frame advances every 4 ticks and wraps after 7.
    for (int i = 1; i <= 40; i++) begin
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_snap($sformatf("stand%0d", i), 0, (i / 4) % 8,
               1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Table: stand, move right, both keys, attack cut short by a hit, hurt.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      do_tick(tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].h);
      chk_snap($sformatf("row%0d", i), tbl[i].st, tbl[i].fr,
               tbl[i].ml, tbl[i].mr, tbl[i].aa, tbl[i].bz);
    end

    // Rest of HURT with hit held: 16 ticks total, hit ignored.
    for (int k = 5; k <= 15; k++) begin
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_snap($sformatf("hurt%0d", k), 4, k / 4, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    // HURT ends; defend held -> DEFEND, then hit ignored while defending.
    do_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_snap("hurt_exit", 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_snap("defend_hit1", 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_snap("defend_hit2", 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_snap("defend_to_left", 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_snap("both_keys", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full attack with key_left held throughout: 36 ticks, hitbox frames 4..6.
    aa_cnt = 0;
    do_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_snap("atk0", 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 1; j <= 35; j++) begin
      do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_snap($sformatf("atk%0d", j), 1, j / 4, 1'b0, 1'b0,
               ((j / 4) >= 4 && (j / 4) <= 6) ? 1'b1 : 1'b0, 1'b1);
      if (s_aa) aa_cnt++;
    end
    chk("attack_active_ticks", aa_cnt, 12);
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_snap("atk_exit", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of HURT (frame 2).
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_snap("hurt2_entry", 4, 0, KB, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_snap("hurt2_f2", 4, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midreset.state", int'(character_state), 0);
    chk("midreset.frame", int'(frame_num), 0);
    chk("midreset.busy", int'(busy), 0);
    chk("midreset.pulses", int'(move_l | move_r | attack_active), 0);
    Reset = 1'b0;

    // frame_clk held high: a single rise gives exactly one step.
    key_right = 1'b1;
    frame_clk = 1'b1;
    mr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (move_r) mr_cnt++;
    end
    chk("held_high.move_r_count", mr_cnt, 1);
    chk("held_high.state", int'(character_state), 3);
    chk("held_high.frame", int'(frame_num), 0);
    frame_clk = 1'b0;
    key_right = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
